total_zeros_vlc_pipe: RTL and testbench
=======================================

TOTAL_ZEROS_VLC_PIPE -- requirements
Module: total_zeros_vlc_pipe

Interface
REQ-001 Parameter: CODE_W, 9, width of code output; must be at least 9, the longest total_zeros codeword.
REQ-002 Parameter: LEN_W, 4, width of code-length output.
REQ-003 Parameter: CNT_W, 16, width of the accumulated bit counter.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 Port: clk, in, 1, sole clock; all state updates on its rising edge.
REQ-006 Port: rst, in, 1, synchronous active-high reset.
REQ-007 Port: in_valid, in, 1, input symbol present.
REQ-008 Port: in_ready, out, 1, block accepts the input symbol this cycle.
REQ-009 Port: in_mode, in, 2, 0 = 4x4 (maxNumCoeff 15/16), 1 = chroma DC 2x2, 2 = chroma DC 2x4, 3 = reserved.
REQ-010 Port: in_total_coeff, in, 5, TotalCoeff.
REQ-011 Port: in_total_zeros, in, 4, TotalZeros.
REQ-012 Port: out_valid, out, 1, output symbol present.
REQ-013 Port: out_ready, in, 1, downstream accepts the output symbol.
REQ-014 Port: out_code, out, CODE_W, codeword right-aligned, upper bits zero.
REQ-015 Port: out_len, out, LEN_W, codeword length in bits; 0 means nothing is emitted.
REQ-016 Port: out_err, out, 1, the symbol was illegal.
REQ-017 Port: cnt_clear, in, 1, clears the bit counter.
REQ-018 Port: bit_count, out, CNT_W, accumulated out_len of accepted output symbols.

Function
REQ-019 The block SHALL map (mode, TotalCoeff, TotalZeros) to the H.264 total_zeros code: Table 9-7/9-8 for mode 0, 9-9a for mode 1 and 9-9b for mode 2.
REQ-020 The block SHALL be a two-stage elastic pipeline: stage 1 registers and validates the input, stage 2 registers the LUT result.
REQ-021 Latency without backpressure SHALL be exactly 2 cycles from input handshake to out_valid.
REQ-022 A symbol SHALL transfer at the input when in_valid and in_ready are both high, and at the output when out_valid and out_ready are both high.
REQ-023 A stage SHALL load when it is empty or its contents move downstream in the same cycle.
REQ-024 The ready signal SHALL follow: in_ready = !s1_valid or s1 advances; the combinational path from out_ready to in_ready is permitted.
REQ-025 Full throughput of one symbol per cycle SHALL be sustained while out_ready is held high.
REQ-026 While out_valid is high and out_ready is low, out_code, out_len and out_err SHALL hold stable.
REQ-027 A symbol SHALL be skipped (out_len = 0, code 0, out_err = 0, still transferred) when TotalCoeff = 0 or TotalCoeff = maxNumCoeff.
REQ-028 maxNumCoeff SHALL be 16 for mode 0, 4 for mode 1 and 8 for mode 2.
REQ-029 A symbol SHALL be illegal (out_err = 1, out_len = 0, code 0, still transferred) when:
  - mode = 3, or
  - TotalCoeff > maxNumCoeff, or
  - TotalZeros > maxNumCoeff - TotalCoeff.
REQ-030 bit_count SHALL add out_len on every output transfer, wrapping modulo 2^CNT_W.
REQ-031 When cnt_clear and an output transfer occur in the same cycle, bit_count SHALL become that transfer's out_len.
REQ-032 Input values SHALL be sampled only on the input handshake; in_* changes while in_ready is low SHALL have no effect.

Reset
REQ-033 When rst is high, both stage valid bits, out_code, out_len, out_err and bit_count SHALL become 0 on the next rising clk edge.
REQ-034 rst SHALL take priority over all handshakes; symbols in flight are discarded with no output transfer.
REQ-035 in_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-036 Package total_zeros_pkg SHALL hold:
  - the mode enumeration;
  - the maxNumCoeff function;
  - the code and length table constants for Tables 9-7, 9-8, 9-9a and 9-9b.
REQ-037 The LUT SHALL be one combinational sub-module, total_zeros_lut, instantiated between stage 1 and stage 2.

Verification
REQ-038 Mode 0 codes, back-to-back with out_ready = 1:
  - TC=1, TZ=0 -> code 1, len 1;
  - TC=1, TZ=1 -> code 3, len 3;
  - TC=1, TZ=15 -> code 1, len 9;
  - TC=15, TZ=1 -> code 1, len 1.
  Each symbol SHALL appear 2 cycles after its input handshake, one output per cycle.
REQ-039 Chroma DC modes:
  - mode 1, TC=1, TZ=3 -> code 0, len 3;
  - mode 1, TC=3, TZ=1 -> code 0, len 1;
  - mode 2, TC=1, TZ=0 -> code 1, len 1.
REQ-040 Skip and illegal cases:
  - mode 0, TC=0 -> len 0, err 0;
  - mode 0, TC=16 -> len 0, err 0;
  - mode 1, TC=2, TZ=3 -> err 1, len 0;
  - mode 3 -> err 1.
REQ-041 Backpressure: hold out_ready = 0 for 5 cycles with 4 symbols offered; in_ready SHALL drop after 2 symbols are accepted, outputs SHALL hold stable, and all 4 symbols SHALL emerge in order with none lost or duplicated.
REQ-042 Counter: stream lengths 1, 3, 9 -> bit_count = 13; assert cnt_clear together with a len-3 transfer -> bit_count = 3.
REQ-043 Reset: assert rst with 2 symbols in flight -> next cycle out_valid = 0 and bit_count = 0, and no stale output afterwards.

Source files
------------

// File: rtl/total_zeros_pkg.sv
// Mode enumeration, maxNumCoeff and total_zeros codeword tables.
// Rows are indexed by TotalCoeff-1, columns by TotalZeros; unused cells are zero.
package total_zeros_pkg;

  typedef enum logic [1:0] {
    MODE_4X4     = 2'd0,
    MODE_CDC_2X2 = 2'd1,
    MODE_CDC_2X4 = 2'd2,
    MODE_RSVD    = 2'd3
  } tz_mode_e;

  function automatic logic [4:0] max_num_coeff(input tz_mode_e mode);
    logic [4:0] v;
    case (mode)
      MODE_4X4:     v = 5'd16;
      MODE_CDC_2X2: v = 5'd4;
      MODE_CDC_2X4: v = 5'd8;
      default:      v = 5'd0;
    endcase
    return v;
  endfunction

  localparam logic [3:0] TZ4X4_LEN [15][16] = '{
    '{4'd1,4'd3,4'd3,4'd4,4'd4,4'd5,4'd5,4'd6,4'd6,4'd7,4'd7,4'd8,4'd8,4'd9,4'd9,4'd9},
    '{4'd3,4'd3,4'd3,4'd3,4'd3,4'd4,4'd4,4'd4,4'd4,4'd5,4'd5,4'd6,4'd6,4'd6,4'd6,4'd0},
    '{4'd4,4'd3,4'd3,4'd3,4'd4,4'd4,4'd3,4'd3,4'd4,4'd5,4'd5,4'd6,4'd5,4'd6,4'd0,4'd0},
    '{4'd5,4'd3,4'd4,4'd4,4'd3,4'd3,4'd3,4'd4,4'd3,4'd4,4'd5,4'd5,4'd5,4'd0,4'd0,4'd0},
    '{4'd4,4'd4,4'd4,4'd3,4'd3,4'd3,4'd3,4'd3,4'd4,4'd5,4'd4,4'd5,4'd0,4'd0,4'd0,4'd0},
    '{4'd6,4'd5,4'd3,4'd3,4'd3,4'd3,4'd3,4'd3,4'd4,4'd3,4'd6,4'd0,4'd0,4'd0,4'd0,4'd0},
    '{4'd6,4'd5,4'd3,4'd3,4'd3,4'd2,4'd3,4'd4,4'd3,4'd6,4'd0,4'd0,4'd0,4'd0,4'd0,4'd0},
    '{4'd6,4'd4,4'd5,4'd3,4'd2,4'd2,4'd3,4'd3,4'd6,4'd0,4'd0,4'd0,4'd0,4'd0,4'd0,4'd0},
    '{4'd6,4'd6,4'd4,4'd2,4'd2,4'd3,4'd2,4'd5,4'd0,4'd0,4'd0,4'd0,4'd0,4'd0,4'd0,4'd0},
    '{4'd5,4'd5,4'd3,4'd2,4'd2,4'd2,4'd4,4'd0,4'd0,4'd0,4'd0,4'd0,4'd0,4'd0,4'd0,4'd0},
    '{4'd4,4'd4,4'd3,4'd3,4'd1,4'd3,4'd0,4'd0,4'd0,4'd0,4'd0,4'd0,4'd0,4'd0,4'd0,4'd0},
    '{4'd4,4'd4,4'd2,4'd1,4'd3,4'd0,4'd0,4'd0,4'd0,4'd0,4'd0,4'd0,4'd0,4'd0,4'd0,4'd0},
    '{4'd3,4'd3,4'd1,4'd2,4'd0,4'd0,4'd0,4'd0,4'd0,4'd0,4'd0,4'd0,4'd0,4'd0,4'd0,4'd0},
    '{4'd2,4'd2,4'd1,4'd0,4'd0,4'd0,4'd0,4'd0,4'd0,4'd0,4'd0,4'd0,4'd0,4'd0,4'd0,4'd0},
    '{4'd1,4'd1,4'd0,4'd0,4'd0,4'd0,4'd0,4'd0,4'd0,4'd0,4'd0,4'd0,4'd0,4'd0,4'd0,4'd0}
  };

  localparam logic [2:0] TZ4X4_CODE [15][16] = '{
    '{3'd1,3'd3,3'd2,3'd3,3'd2,3'd3,3'd2,3'd3,3'd2,3'd3,3'd2,3'd3,3'd2,3'd3,3'd2,3'd1},
    '{3'd7,3'd6,3'd5,3'd4,3'd3,3'd5,3'd4,3'd3,3'd2,3'd3,3'd2,3'd3,3'd2,3'd1,3'd0,3'd0},
    '{3'd5,3'd7,3'd6,3'd5,3'd4,3'd3,3'd4,3'd3,3'd2,3'd3,3'd2,3'd1,3'd1,3'd0,3'd0,3'd0},
    '{3'd3,3'd7,3'd5,3'd4,3'd6,3'd5,3'd4,3'd3,3'd3,3'd2,3'd2,3'd1,3'd0,3'd0,3'd0,3'd0},
    '{3'd5,3'd4,3'd3,3'd7,3'd6,3'd5,3'd4,3'd3,3'd2,3'd1,3'd1,3'd0,3'd0,3'd0,3'd0,3'd0},
    '{3'd1,3'd1,3'd7,3'd6,3'd5,3'd4,3'd3,3'd2,3'd1,3'd1,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0},
    '{3'd1,3'd1,3'd5,3'd4,3'd3,3'd3,3'd2,3'd1,3'd1,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0},
    '{3'd1,3'd1,3'd1,3'd3,3'd3,3'd2,3'd2,3'd1,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0},
    '{3'd1,3'd0,3'd1,3'd3,3'd2,3'd1,3'd1,3'd1,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0},
    '{3'd1,3'd0,3'd1,3'd3,3'd2,3'd1,3'd1,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0},
    '{3'd0,3'd1,3'd1,3'd2,3'd1,3'd3,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0},
    '{3'd0,3'd1,3'd1,3'd1,3'd1,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0},
    '{3'd0,3'd1,3'd1,3'd1,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0},
    '{3'd0,3'd1,3'd1,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0},
    '{3'd0,3'd1,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0}
  };

  localparam logic [3:0] TZ2X2_LEN [3][4] = '{
    '{4'd1,4'd2,4'd3,4'd3}, '{4'd1,4'd2,4'd2,4'd0}, '{4'd1,4'd1,4'd0,4'd0}
  };
  localparam logic [2:0] TZ2X2_CODE [3][4] = '{
    '{3'd1,3'd1,3'd1,3'd0}, '{3'd1,3'd1,3'd0,3'd0}, '{3'd1,3'd0,3'd0,3'd0}
  };

  localparam logic [3:0] TZ2X4_LEN [7][8] = '{
    '{4'd1,4'd3,4'd3,4'd4,4'd4,4'd4,4'd5,4'd5},
    '{4'd3,4'd2,4'd3,4'd3,4'd3,4'd3,4'd3,4'd0},
    '{4'd3,4'd3,4'd2,4'd2,4'd3,4'd3,4'd0,4'd0},
    '{4'd3,4'd2,4'd2,4'd2,4'd3,4'd0,4'd0,4'd0},
    '{4'd2,4'd2,4'd2,4'd2,4'd0,4'd0,4'd0,4'd0},
    '{4'd2,4'd2,4'd1,4'd0,4'd0,4'd0,4'd0,4'd0},
    '{4'd1,4'd1,4'd0,4'd0,4'd0,4'd0,4'd0,4'd0}
  };
  localparam logic [2:0] TZ2X4_CODE [7][8] = '{
    '{3'd1,3'd2,3'd3,3'd2,3'd3,3'd1,3'd1,3'd0},
    '{3'd0,3'd1,3'd1,3'd4,3'd5,3'd6,3'd7,3'd0},
    '{3'd0,3'd1,3'd1,3'd2,3'd6,3'd7,3'd0,3'd0},
    '{3'd6,3'd0,3'd1,3'd2,3'd7,3'd0,3'd0,3'd0},
    '{3'd0,3'd1,3'd2,3'd3,3'd0,3'd0,3'd0,3'd0},
    '{3'd0,3'd1,3'd1,3'd0,3'd0,3'd0,3'd0,3'd0},
    '{3'd0,3'd1,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0}
  };

endpackage

// File: rtl/total_zeros_lut.sv
// Combinational total_zeros codeword lookup; any cell outside the
// table for the selected mode yields code 0 / length 0.
module total_zeros_lut
  import total_zeros_pkg::*;
(
  input  tz_mode_e   i_mode,
  input  logic [4:0] i_total_coeff,
  input  logic [3:0] i_total_zeros,
  output logic [2:0] o_code,
  output logic [3:0] o_len
);

  logic [3:0] w_row4;
  logic [1:0] w_row2x2;
  logic [2:0] w_row2x4;

  assign w_row4   = i_total_coeff[3:0] - 4'd1;
  assign w_row2x2 = i_total_coeff[1:0] - 2'd1;
  assign w_row2x4 = i_total_coeff[2:0] - 3'd1;

  always_comb begin
    o_code = '0;
    o_len  = '0;
    case (i_mode)
      MODE_4X4: begin
        if (i_total_coeff >= 5'd1 && i_total_coeff <= 5'd15) begin
          o_code = TZ4X4_CODE[w_row4][i_total_zeros];
          o_len  = TZ4X4_LEN[w_row4][i_total_zeros];
        end
      end
      MODE_CDC_2X2: begin
        if (i_total_coeff >= 5'd1 && i_total_coeff <= 5'd3 && i_total_zeros <= 4'd3) begin
          o_code = TZ2X2_CODE[w_row2x2][i_total_zeros[1:0]];
          o_len  = TZ2X2_LEN[w_row2x2][i_total_zeros[1:0]];
        end
      end
      MODE_CDC_2X4: begin
        if (i_total_coeff >= 5'd1 && i_total_coeff <= 5'd7 && i_total_zeros <= 4'd7) begin
          o_code = TZ2X4_CODE[w_row2x4][i_total_zeros[2:0]];
          o_len  = TZ2X4_LEN[w_row2x4][i_total_zeros[2:0]];
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/total_zeros_vlc_pipe.sv
// Two-stage elastic total_zeros VLC encoder: stage 1 captures and validates,
// stage 2 holds the looked-up codeword; a bit counter sums emitted lengths.
module total_zeros_vlc_pipe
  import total_zeros_pkg::*;
#(
  parameter int CODE_W = 9,
  parameter int LEN_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_mode,
  input  logic [4:0]        in_total_coeff,
  input  logic [3:0]        in_total_zeros,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic [LEN_W-1:0]  out_len,
  output logic              out_err,
  input  logic              cnt_clear,
  output logic [CNT_W-1:0]  bit_count
);

  tz_mode_e          w_mode;
  logic [4:0]        w_max;
  logic [4:0]        w_room;
  logic              w_err;
  logic              w_skip;
  logic              w_s2_en;
  logic              w_in_fire;
  logic              w_out_fire;
  logic [2:0]        w_lut_code;
  logic [3:0]        w_lut_len;

  logic              r_s1_vld;
  tz_mode_e          r_s1_mode;
  logic [4:0]        r_s1_tc;
  logic [3:0]        r_s1_tz;
  logic              r_s1_skip;
  logic              r_s1_err;

  logic              r_s2_vld;
  logic [CODE_W-1:0] r_s2_code;
  logic [LEN_W-1:0]  r_s2_len;
  logic              r_s2_err;
  logic [CNT_W-1:0]  r_cnt;

  // w_room is only meaningful once TotalCoeff <= maxNumCoeff is known
  assign w_mode = tz_mode_e'(in_mode);
  assign w_max  = max_num_coeff(w_mode);
  assign w_room = w_max - in_total_coeff;
  assign w_err  = (w_mode == MODE_RSVD) || (in_total_coeff > w_max) ||
                  ({1'b0, in_total_zeros} > w_room);
  assign w_skip = !w_err && (in_total_coeff == 5'd0 || in_total_coeff == w_max);

  assign w_s2_en    = !r_s2_vld || out_ready;
  assign in_ready   = !r_s1_vld || w_s2_en;
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = r_s2_vld && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld <= 1'b0;
    end else if (in_ready) begin
      r_s1_vld <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      r_s1_mode <= w_mode;
      r_s1_tc   <= in_total_coeff;
      r_s1_tz   <= in_total_zeros;
      r_s1_skip <= w_skip;
      r_s1_err  <= w_err;
    end
  end

  total_zeros_lut u_lut (
    .i_mode        (r_s1_mode),
    .i_total_coeff (r_s1_tc),
    .i_total_zeros (r_s1_tz),
    .o_code        (w_lut_code),
    .o_len         (w_lut_len)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_vld  <= 1'b0;
      r_s2_code <= '0;
      r_s2_len  <= '0;
      r_s2_err  <= 1'b0;
    end else if (w_s2_en) begin
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_s2_code <= (r_s1_skip || r_s1_err) ? '0 : CODE_W'(w_lut_code);
        r_s2_len  <= (r_s1_skip || r_s1_err) ? '0 : LEN_W'(w_lut_len);
        r_s2_err  <= r_s1_err;
      end
    end
  end

  // A clear coinciding with a transfer restarts the count at that length
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_out_fire) begin
      r_cnt <= (cnt_clear ? '0 : r_cnt) + CNT_W'(r_s2_len);
    end else if (cnt_clear) begin
      r_cnt <= '0;
    end
  end

  assign out_valid = r_s2_vld;
  assign out_code  = r_s2_code;
  assign out_len   = r_s2_len;
  assign out_err   = r_s2_err;
  assign bit_count = r_cnt;

endmodule

// File: tb/tb_total_zeros_vlc_pipe.sv
// Directed table-driven bench for total_zeros_vlc_pipe plus hand-written
// backpressure, counter and reset sequences.
module tb_total_zeros_vlc_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_mode;
  logic [4:0]  in_total_coeff;
  logic [3:0]  in_total_zeros;
  logic        out_valid;
  logic        out_ready;
  logic [8:0]  out_code;
  logic [3:0]  out_len;
  logic        out_err;
  logic        cnt_clear;
  logic [15:0] bit_count;

  total_zeros_vlc_pipe #(.CODE_W(9), .LEN_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_total_coeff(in_total_coeff), .in_total_zeros(in_total_zeros),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_code(out_code), .out_len(out_len), .out_err(out_err),
    .cnt_clear(cnt_clear), .bit_count(bit_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    logic [4:0] tc;
    logic [3:0] tz;
    logic [8:0] code;
    logic [3:0] len;
    logic       err;
  } vec_t;

  localparam int NV = 21;
  vec_t vt [NV];
  vec_t bp [4];

  int n_vec = 0;
  int n_bad = 0;
  logic [15:0] exp_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    in_mode        = v.mode;
    in_total_coeff = v.tc;
    in_total_zeros = v.tz;
  endtask

  task automatic push(input logic [1:0] m, input logic [4:0] tc, input logic [3:0] tz);
    bit done = 0;
    in_valid = 1'b1; in_mode = m; in_total_coeff = tc; in_total_zeros = tz;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (in_ready) done = 1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) chk("push_timeout", 0, 1);
  endtask

  initial begin
    vt[0]  = '{2'd0, 5'd1,  4'd0,  9'd1, 4'd1, 1'b0};
    vt[1]  = '{2'd0, 5'd1,  4'd1,  9'd3, 4'd3, 1'b0};
    vt[2]  = '{2'd0, 5'd1,  4'd15, 9'd1, 4'd9, 1'b0};
    vt[3]  = '{2'd0, 5'd15, 4'd1,  9'd1, 4'd1, 1'b0};
    vt[4]  = '{2'd1, 5'd1,  4'd3,  9'd0, 4'd3, 1'b0};
    vt[5]  = '{2'd1, 5'd3,  4'd1,  9'd0, 4'd1, 1'b0};
    vt[6]  = '{2'd2, 5'd1,  4'd0,  9'd1, 4'd1, 1'b0};
    vt[7]  = '{2'd0, 5'd0,  4'd5,  9'd0, 4'd0, 1'b0};
    vt[8]  = '{2'd0, 5'd16, 4'd0,  9'd0, 4'd0, 1'b0};
    vt[9]  = '{2'd1, 5'd2,  4'd3,  9'd0, 4'd0, 1'b1};
    vt[10] = '{2'd3, 5'd1,  4'd0,  9'd0, 4'd0, 1'b1};
    vt[11] = '{2'd0, 5'd2,  4'd14, 9'd0, 4'd6, 1'b0};
    vt[12] = '{2'd0, 5'd3,  4'd7,  9'd3, 4'd3, 1'b0};
    vt[13] = '{2'd2, 5'd3,  4'd4,  9'd6, 4'd3, 1'b0};
    vt[14] = '{2'd2, 5'd8,  4'd0,  9'd0, 4'd0, 1'b0};
    vt[15] = '{2'd0, 5'd5,  4'd12, 9'd0, 4'd0, 1'b1};
    vt[16] = '{2'd0, 5'd17, 4'd0,  9'd0, 4'd0, 1'b1};
    vt[17] = '{2'd2, 5'd4,  4'd3,  9'd2, 4'd2, 1'b0};
    vt[18] = '{2'd0, 5'd10, 4'd4,  9'd2, 4'd2, 1'b0};
    vt[19] = '{2'd0, 5'd6,  4'd10, 9'd0, 4'd6, 1'b0};
    vt[20] = '{2'd0, 5'd15, 4'd0,  9'd0, 4'd1, 1'b0};
    bp[0]  = '{2'd0, 5'd1,  4'd1,  9'd3, 4'd3, 1'b0};
    bp[1]  = '{2'd0, 5'd1,  4'd15, 9'd1, 4'd9, 1'b0};
    bp[2]  = '{2'd1, 5'd1,  4'd3,  9'd0, 4'd3, 1'b0};
    bp[3]  = '{2'd0, 5'd3,  4'd7,  9'd3, 4'd3, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cnt_clear = 1'b0;
    in_mode = '0; in_total_coeff = '0; in_total_zeros = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state, then back-to-back stream with two-cycle latency
    exp_cnt = '0;
    for (int c = 0; c < NV + 2; c++) begin
      in_valid = (c < NV);
      if (c < NV) drive(vt[c]);
      @(negedge clk);
      if (c == 0) begin
        chk("rst_out_code", out_code, 0);
        chk("rst_out_len", out_len, 0);
        chk("rst_out_err", out_err, 0);
      end
      if (c < NV) chk("stream_in_ready", in_ready, 1);
      chk("stream_bit_count", bit_count, exp_cnt);
      if (c >= 2) begin
        chk($sformatf("vec%0d_valid", c - 2), out_valid, 1);
        chk($sformatf("vec%0d_code", c - 2), out_code, vt[c-2].code);
        chk($sformatf("vec%0d_len", c - 2), out_len, vt[c-2].len);
        chk($sformatf("vec%0d_err", c - 2), out_err, vt[c-2].err);
        exp_cnt = exp_cnt + 16'(vt[c-2].len);
      end else begin
        chk("stream_early_valid", out_valid, 0);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("stream_final_count", bit_count, exp_cnt);
    chk("stream_drained", out_valid, 0);
    @(posedge clk); #1;

    // Backpressure: out_ready low for 5 cycles, junk on in_* while stalled
    begin
      int idx = 0;
      int nrx = 0;
      vec_t rx [8];
      for (int c = 0; c < 20; c++) begin
        out_ready = (c >= 5);
        in_valid  = (idx < 4);
        if (idx < 4) drive(bp[idx]);
        if (c >= 2 && c < 5) begin
          in_mode = 2'd3; in_total_coeff = 5'd31; in_total_zeros = 4'd15;
        end
        @(negedge clk);
        if (c == 2) begin
          chk("bp_in_ready_low", in_ready, 0);
          chk("bp_accepted", idx, 2);
        end
        if (c >= 2 && c < 5) begin
          chk("bp_hold_valid", out_valid, 1);
          chk("bp_hold_code", out_code, bp[0].code);
          chk("bp_hold_len", out_len, bp[0].len);
          chk("bp_hold_err", out_err, 0);
        end
        if (out_valid && out_ready && nrx < 8) begin
          rx[nrx] = '{2'd0, 5'd0, 4'd0, out_code, out_len, out_err};
          nrx++;
        end
        if (in_valid && in_ready) idx++;
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
      chk("bp_rx_count", nrx, 4);
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("bp_rx%0d_code", i), rx[i].code, bp[i].code);
        chk($sformatf("bp_rx%0d_len", i), rx[i].len, bp[i].len);
      end
    end

    // Counter: clear, accumulate 1+3+9, then clear together with a len-3 transfer
    out_ready = 1'b1;
    cnt_clear = 1'b1;
    @(posedge clk); #1;
    cnt_clear = 1'b0;
    @(negedge clk);
    chk("cnt_clear_idle", bit_count, 0);
    @(posedge clk); #1;
    push(2'd0, 5'd1, 4'd0);
    push(2'd0, 5'd1, 4'd1);
    push(2'd0, 5'd1, 4'd15);
    repeat (4) @(posedge clk);
    #1;
    @(negedge clk);
    chk("cnt_sum13", bit_count, 13);
    @(posedge clk); #1;
    push(2'd0, 5'd1, 4'd1);
    begin
      bit seen = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
        @(negedge clk);
        if (out_valid) begin
          seen = 1;
          cnt_clear = 1'b1;
        end
        @(posedge clk); #1;
      end
      cnt_clear = 1'b0;
      if (!seen) chk("cnt_wait_timeout", 0, 1);
    end
    @(negedge clk);
    chk("cnt_clear_with_xfer", bit_count, 3);
    @(posedge clk); #1;

    // Reset with two symbols in flight
    out_ready = 1'b0;
    in_valid = 1'b1; drive(bp[0]);
    @(posedge clk); #1;
    drive(bp[1]);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("inflight_valid", out_valid, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rst_flush_valid", out_valid, 0);
    chk("rst_flush_count", bit_count, 0);
    chk("rst_flush_len", out_len, 0);
    chk("rst_in_ready", in_ready, 1);
    begin
      int stale = 0;
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        if (out_valid) stale++;
      end
      chk("rst_no_stale", stale, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
